multicycle_control: RTL and testbench

- Moore-FSM control unit for the multi-cycle MIPS datapath.
- Successor to the single-cycle combinational decoder: parametrised opcode and ALU-op widths, configurable opcode encodings, and a per-instruction state sequence with a memory-ready stall handshake.
- Sits between the instruction register opcode field and the shared-memory / register-file / ALU / PC datapath muxes.

---
 rtl/multicycle_control_if.sv | 35 +++
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS control FSM (master) and the datapath (slave).
interface multicycle_control_if #(
  parameter int unsigned OPCODE_W = 5,
  parameter int unsigned ALUOP_W  = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                MemToReg;
  logic                RegDst;
  logic                RegWrite;
  logic                ALUsrcA;
  logic [1:0]          ALUsrcB;
  logic [ALUOP_W-1:0]  ALUop;
  logic [1:0]          PCSource;
  logic [3:0]          state;
  logic                illegal;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegDst, RegWrite, ALUsrcA, ALUsrcB, ALUop, PCSource, state, illegal
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegDst, RegWrite, ALUsrcA, ALUsrcB, ALUop, PCSource, state, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath with memory-ready stalls.
// MC_ILLEGAL_TRAP_EN: unknown opcodes trap (sticky illegal) instead of acting as a NOP.
module multicycle_control #(
  parameter int unsigned OPCODE_W = 5,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned OP_RTYPE = 'h00,
  parameter int unsigned OP_ADDI  = 'h01,
  parameter int unsigned OP_J     = 'h02,
  parameter int unsigned OP_BEQ   = 'h04,
  parameter int unsigned OP_LW    = 'h05,
  parameter int unsigned OP_SW    = 'h0A
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master ctrl
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    RWB    = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    ADDIEX = 4'd11,
    ADDIWB = 4'd12,
    TRAP   = 4'd13
  } state_t;

  localparam logic [OPCODE_W-1:0] OPC_RTYPE = OPCODE_W'(OP_RTYPE);
  localparam logic [OPCODE_W-1:0] OPC_ADDI  = OPCODE_W'(OP_ADDI);
  localparam logic [OPCODE_W-1:0] OPC_J     = OPCODE_W'(OP_J);
  localparam logic [OPCODE_W-1:0] OPC_BEQ   = OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] OPC_LW    = OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] OPC_SW    = OPCODE_W'(OP_SW);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

  state_t              stateReg;
  state_t              stateNext;
  logic [OPCODE_W-1:0] opReg;
  logic [OPCODE_W-1:0] opNext;

  // State and captured opcode; reset aborts any access immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      opReg    <= '0;
    end else begin
      stateReg <= stateNext;
      opReg    <= opNext;
    end
  end

  // Next state and state-decoded strobes; only IRWrite/PCWrite in FETCH see mem_ready.
  always_comb begin
    stateNext        = stateReg;
    opNext           = opReg;
    ctrl.PCWrite     = 1'b0;
    ctrl.PCWriteCond = 1'b0;
    ctrl.IorD        = 1'b0;
    ctrl.MemRead     = 1'b0;
    ctrl.MemWrite    = 1'b0;
    ctrl.IRWrite     = 1'b0;
    ctrl.MemToReg    = 1'b0;
    ctrl.RegDst      = 1'b0;
    ctrl.RegWrite    = 1'b0;
    ctrl.ALUsrcA     = 1'b0;
    ctrl.ALUsrcB     = 2'b00;
    ctrl.ALUop       = ALU_ADD;
    ctrl.PCSource    = 2'b00;
    ctrl.illegal     = 1'b0;
    ctrl.state       = stateReg;

    case (stateReg)
      IDLE: stateNext = FETCH;

      FETCH: begin
        ctrl.MemRead = 1'b1;
        ctrl.ALUsrcB = 2'b01;
        ctrl.IRWrite = ctrl.mem_ready;
        ctrl.PCWrite = ctrl.mem_ready;
        if (ctrl.mem_ready) stateNext = DECODE;
      end

      DECODE: begin
        ctrl.ALUsrcB = 2'b11;
        opNext       = ctrl.opcode;
        if (ctrl.opcode == OPC_LW || ctrl.opcode == OPC_SW) stateNext = MEMADR;
        else if (ctrl.opcode == OPC_RTYPE) stateNext = EXEC;
        else if (ctrl.opcode == OPC_BEQ)   stateNext = BRANCH;
        else if (ctrl.opcode == OPC_J)     stateNext = JUMP;
        else if (ctrl.opcode == OPC_ADDI)  stateNext = ADDIEX;
        else begin
`ifdef MC_ILLEGAL_TRAP_EN
          stateNext = TRAP;
`else
          stateNext    = FETCH;
          ctrl.illegal = 1'b1;
`endif
        end
      end

      MEMADR, ADDIEX: begin
        ctrl.ALUsrcA = 1'b1;
        ctrl.ALUsrcB = 2'b10;
        if (stateReg == ADDIEX) stateNext = ADDIWB;
        else stateNext = (opReg == OPC_LW) ? MEMRD : MEMWR;
      end

      MEMRD: begin
        ctrl.MemRead = 1'b1;
        ctrl.IorD    = 1'b1;
        if (ctrl.mem_ready) stateNext = MEMWB;
      end

      MEMWR: begin
        ctrl.MemWrite = 1'b1;
        ctrl.IorD     = 1'b1;
        if (ctrl.mem_ready) stateNext = FETCH;
      end

      MEMWB: begin
        ctrl.RegWrite = 1'b1;
        ctrl.MemToReg = 1'b1;
        stateNext     = FETCH;
      end

      EXEC: begin
        ctrl.ALUsrcA = 1'b1;
        ctrl.ALUop   = ALU_FUNCT;
        stateNext    = RWB;
      end

      RWB: begin
        ctrl.RegWrite = 1'b1;
        ctrl.RegDst   = 1'b1;
        stateNext     = FETCH;
      end

      ADDIWB: begin
        ctrl.RegWrite = 1'b1;
        stateNext     = FETCH;
      end

      BRANCH: begin
        ctrl.ALUsrcA     = 1'b1;
        ctrl.ALUop       = ALU_SUB;
        ctrl.PCWriteCond = 1'b1;
        ctrl.PCSource    = 2'b01;
        stateNext        = FETCH;
      end

      JUMP: begin
        ctrl.PCWrite  = 1'b1;
        ctrl.PCSource = 2'b10;
        stateNext     = FETCH;
      end

      // Held until reset; only reachable when trapping is enabled.
      TRAP: begin
        stateNext = TRAP;
`ifdef MC_ILLEGAL_TRAP_EN
        ctrl.illegal = 1'b1;
`endif
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control (OPCODE_W=6, ALUOP_W=4 build).
module tb_multicycle_control;

  localparam int unsigned OW = 6;
  localparam int unsigned AW = 4;

  localparam logic [OW-1:0] T_RTYPE = OW'('h00);
  localparam logic [OW-1:0] T_ADDI  = OW'('h01);
  localparam logic [OW-1:0] T_J     = OW'('h02);
  localparam logic [OW-1:0] T_BEQ   = OW'('h04);
  localparam logic [OW-1:0] T_LW    = OW'('h05);
  localparam logic [OW-1:0] T_SW    = OW'('h0A);

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       srcA;
    logic [1:0] srcB;
    logic [3:0] aluop;
    logic [1:0] pcs;
    logic       ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_if #(.OPCODE_W(OW), .ALUOP_W(AW)) bus ();

  multicycle_control #(.OPCODE_W(OW), .ALUOP_W(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (bus)
  );

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  // Expected outputs of each state, straight from the state/output table.
  function automatic exp_t mk(input int st, input bit ready, input bit ill);
    exp_t e;
    e    = '0;
    e.st = 4'(st);
    case (st)
      1:  begin e.mrd = 1; e.srcB = 2'b01; e.irw = ready; e.pcw = ready; end
      2:  e.srcB = 2'b11;
      3, 11: begin e.srcA = 1; e.srcB = 2'b10; end
      4:  begin e.mrd = 1; e.iord = 1; end
      5:  begin e.rw = 1; e.m2r = 1; end
      6:  begin e.mwr = 1; e.iord = 1; end
      7:  begin e.srcA = 1; e.aluop = 4'd2; end
      8:  begin e.rw = 1; e.rdst = 1; end
      9:  begin e.srcA = 1; e.aluop = 4'd1; e.pcwc = 1; e.pcs = 2'b01; end
      10: begin e.pcw = 1; e.pcs = 2'b10; end
      12: e.rw = 1;
      default: ;
    endcase
    e.ill = ill;
    return e;
  endfunction

  // Monitor: compares every presented cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t a;
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      a = {bus.state, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
           bus.IRWrite, bus.MemToReg, bus.RegDst, bus.RegWrite, bus.ALUsrcA, bus.ALUsrcB,
           bus.ALUop, bus.PCSource, bus.illegal};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_check %0d: got state=%0d vec=%h, required state=%0d vec=%h",
                 checks, a.st, a, e.st, e);
      end
    end
  end

  function automatic logic [OW-1:0] rndOp();
    return OW'($urandom);
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // One clock: drive inputs, queue the expectation, advance past the edge.
  task automatic cyc(input int st, input bit ready, input logic [OW-1:0] op, input bit ill);
    bus.mem_ready = ready;
    bus.opcode    = op;
    expQ.push_back(mk(st, ready, ill));
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    cyc(0, rb(), rndOp(), 0);
    rst_n = 1'b1;
    cyc(0, rb(), rndOp(), 0);
  endtask

  task automatic runInstr(input logic [OW-1:0] op, input int fStall, input int mStall,
                          input bit abort);
    repeat (fStall) cyc(1, 0, rndOp(), 0);
    cyc(1, 1, rndOp(), 0);
    if (op == T_LW) begin
      cyc(2, rb(), op, 0);
      cyc(3, rb(), rndOp(), 0);
      repeat (mStall) cyc(4, 0, rndOp(), 0);
      cyc(4, 1, rndOp(), 0);
      cyc(5, rb(), rndOp(), 0);
    end else if (op == T_SW) begin
      cyc(2, rb(), op, 0);
      cyc(3, rb(), rndOp(), 0);
      repeat (mStall) cyc(6, 0, rndOp(), 0);
      if (abort) begin
        // Reset lands while MEMWR is still stalled.
        rst_n = 1'b0;
        cyc(0, 0, rndOp(), 0);
        rst_n = 1'b1;
        cyc(0, rb(), rndOp(), 0);
      end else begin
        cyc(6, 1, rndOp(), 0);
      end
    end else if (op == T_RTYPE) begin
      cyc(2, rb(), op, 0);
      cyc(7, rb(), rndOp(), 0);
      cyc(8, rb(), rndOp(), 0);
    end else if (op == T_BEQ) begin
      cyc(2, rb(), op, 0);
      cyc(9, rb(), rndOp(), 0);
    end else if (op == T_J) begin
      cyc(2, rb(), op, 0);
      cyc(10, rb(), rndOp(), 0);
    end else if (op == T_ADDI) begin
      cyc(2, rb(), op, 0);
      cyc(11, rb(), rndOp(), 0);
      cyc(12, rb(), rndOp(), 0);
    end else begin
`ifdef MC_ILLEGAL_TRAP_EN
      cyc(2, rb(), op, 0);
      repeat (3) cyc(13, rb(), rndOp(), 1);
      doReset();
`else
      cyc(2, rb(), op, 1);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1);
  end

  initial begin
    logic [OW-1:0] op;
    logic [OW-1:0] legal[6];
    legal = '{T_RTYPE, T_ADDI, T_J, T_BEQ, T_LW, T_SW};

    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode    = '0;
    @(posedge clk);
    #1;
    doReset();

    // Directed scenarios first.
    runInstr(T_LW, 0, 0, 0);
    runInstr(T_SW, 0, 2, 0);
    runInstr(T_RTYPE, 0, 0, 0);
    runInstr(T_BEQ, 0, 0, 0);
    runInstr(T_J, 0, 0, 0);
    runInstr(OW'('h1F), 0, 0, 0);
    runInstr(OW'('h21), 1, 0, 0);
    runInstr(T_SW, 1, 2, 1);
    runInstr(T_ADDI, 0, 0, 0);
    runInstr(T_LW, 2, 3, 0);

    // Randomized instruction stream.
    for (int i = 0; i < 200; i++) begin
      int sel;
      sel = int'($urandom_range(0, 8));
      if (sel < 6) op = legal[sel];
      else op = rndOp();
      runInstr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
               (op == T_SW) && ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, required 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
